// File: rtl/game_state_controller.sv
// Game-flow controller for Frogger: sequences idle, play, pause, death freeze
// and game over, and keeps lives, level and the per-life countdown timer.
module game_state_controller #(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned NB_LIVES   = 3,
    parameter int unsigned LEVEL_TIME = 30,
    parameter int unsigned DEATH_HOLD = 12_500_000,
    parameter int unsigned MAX_LEVEL  = 15,
    parameter int unsigned LEVEL_W    = 4
) (
    input  logic                                i_Clk,
    input  logic                                i_Rst_L,
    input  logic                                i_Start,
    input  logic                                i_Pause,
    input  logic                                i_Has_Collided,
    input  logic                                i_Level_Up,
    output logic [2:0]                          o_State,
    output logic                                o_Game_Active,
    output logic                                o_Frog_Reset,
    output logic                                o_Death,
    output logic [$clog2(NB_LIVES+1)-1:0]       o_Lives,
    output logic [LEVEL_W-1:0]                  o_Level,
    output logic [$clog2(LEVEL_TIME+1)-1:0]     o_Time_Left
);

    localparam int unsigned LIVES_W = $clog2(NB_LIVES + 1);
    localparam int unsigned TIME_W  = $clog2(LEVEL_TIME + 1);
    localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned HOLD_W  = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(DEATH_HOLD - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NB_LIVES);
    localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(LEVEL_TIME);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_PAUSED    = 3'd2,
        ST_DYING     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [TIME_W-1:0]    time_q, time_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 frog_reset_q, frog_reset_d;
    logic                 death_q, death_d;
    logic                 game_active_q;

    logic                 start_q, start_prev_q;
    logic                 pause_q, pause_prev_q;
    logic                 start_edge;
    logic                 pause_edge;

    // Switch level registers; only rising edges are acted upon.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            start_q      <= i_Start;
            start_prev_q <= start_q;
            pause_q      <= i_Pause;
            pause_prev_q <= pause_q;
        end
    end

    assign start_edge = start_q & ~start_prev_q;
    assign pause_edge = pause_q & ~pause_prev_q;

    // Next-state, counter and pulse logic.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        time_d       = time_q;
        presc_d      = presc_q;
        hold_d       = hold_q;
        frog_reset_d = 1'b0;
        death_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge) begin
                    state_d      = ST_RUNNING;
                    lives_d      = LIVES_INIT;
                    level_d      = '0;
                    time_d       = TIME_INIT;
                    presc_d      = '0;
                    hold_d       = '0;
                    frog_reset_d = 1'b1;
                end
            end

            ST_RUNNING: begin
                if (i_Has_Collided || (time_q == '0)) begin
                    // Death wins over every other event in the same cycle.
                    state_d = ST_DYING;
                    death_d = 1'b1;
                    hold_d  = '0;
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                end else if (i_Level_Up) begin
                    if (level_q < LEVEL_MAX) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                    time_d       = TIME_INIT;
                    presc_d      = '0;
                    frog_reset_d = 1'b1;
                end else begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (time_q != '0) begin
                            time_d = time_q - TIME_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                    if (pause_edge) begin
                        state_d = ST_PAUSED;
                    end
                end
            end

            ST_PAUSED: begin
                if (pause_edge) begin
                    state_d = ST_RUNNING;
                end
            end

            ST_DYING: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (lives_q != '0) begin
                        state_d      = ST_RUNNING;
                        time_d       = TIME_INIT;
                        presc_d      = '0;
                        frog_reset_d = 1'b1;
                    end else begin
                        state_d = ST_GAME_OVER;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q       <= ST_IDLE;
            lives_q       <= LIVES_INIT;
            level_q       <= '0;
            time_q        <= TIME_INIT;
            presc_q       <= '0;
            hold_q        <= '0;
            frog_reset_q  <= 1'b0;
            death_q       <= 1'b0;
            game_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            time_q        <= time_d;
            presc_q       <= presc_d;
            hold_q        <= hold_d;
            frog_reset_q  <= frog_reset_d;
            death_q       <= death_d;
            game_active_q <= (state_d == ST_RUNNING);
        end
    end

    assign o_State       = state_q;
    assign o_Game_Active = game_active_q;
    assign o_Frog_Reset  = frog_reset_q;
    assign o_Death       = death_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Time_Left   = time_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: a behavioural model predicts
// each cycle's outputs, a monitor compares them against the DUT.
module tb_game_state_controller;

    localparam int CLK_HZ     = 10;
    localparam int NB_LIVES   = 2;
    localparam int LEVEL_TIME = 3;
    localparam int DEATH_HOLD = 4;
    localparam int MAX_LEVEL  = 2;
    localparam int LEVEL_W    = 4;

    logic clk;
    logic rst_n, start, pause, coll, lvl;
    logic [2:0]                         st;
    logic                               act, fr, dth;
    logic [$clog2(NB_LIVES+1)-1:0]      lives;
    logic [LEVEL_W-1:0]                 level;
    logic [$clog2(LEVEL_TIME+1)-1:0]    tl;

    game_state_controller #(
        .CLK_HZ     (CLK_HZ),
        .NB_LIVES   (NB_LIVES),
        .LEVEL_TIME (LEVEL_TIME),
        .DEATH_HOLD (DEATH_HOLD),
        .MAX_LEVEL  (MAX_LEVEL),
        .LEVEL_W    (LEVEL_W)
    ) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Start        (start),
        .i_Pause        (pause),
        .i_Has_Collided (coll),
        .i_Level_Up     (lvl),
        .o_State        (st),
        .o_Game_Active  (act),
        .o_Frog_Reset   (fr),
        .o_Death        (dth),
        .o_Lives        (lives),
        .o_Level        (level),
        .o_Time_Left    (tl)
    );

    typedef struct {
        int st;
        int act;
        int fr;
        int dth;
        int lives;
        int level;
        int tl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Behavioural model: game phase as the visible state code, time left
    // derived from the number of played cycles since the last reload.
    int m_mode, m_lives, m_level, m_played, m_frozen;
    int m_s1, m_s2, m_p1, m_p2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int seconds_left();
        int used;
        used = m_played / CLK_HZ;
        return (used >= LEVEL_TIME) ? 0 : LEVEL_TIME - used;
    endfunction

    task automatic new_game(output int pulse);
        m_mode   = 1;
        m_lives  = NB_LIVES;
        m_level  = 0;
        m_played = 0;
        m_frozen = 0;
        pulse    = 1;
    endtask

    task automatic model_step(input int r, input int s, input int p,
                              input int c, input int l, output exp_t e);
        int start_rise, pause_rise, frog, died;
        frog = 0;
        died = 0;
        if (r == 0) begin
            m_mode = 0; m_lives = NB_LIVES; m_level = 0;
            m_played = 0; m_frozen = 0;
            m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;
        end else begin
            start_rise = m_s1 & ~m_s2;
            pause_rise = m_p1 & ~m_p2;
            if (m_mode == 0 || m_mode == 4) begin
                if (start_rise != 0) new_game(frog);
            end else if (m_mode == 1) begin
                if (c != 0 || seconds_left() == 0) begin
                    m_mode = 3; died = 1; m_frozen = 0;
                    if (m_lives > 0) m_lives = m_lives - 1;
                end else if (l != 0) begin
                    m_level  = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
                    m_played = 0;
                    frog     = 1;
                end else begin
                    m_played = m_played + 1;
                    if (pause_rise != 0) m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (pause_rise != 0) m_mode = 1;
            end else if (m_mode == 3) begin
                m_frozen = m_frozen + 1;
                if (m_frozen == DEATH_HOLD) begin
                    if (m_lives > 0) begin
                        m_mode = 1; m_played = 0; frog = 1;
                    end else begin
                        m_mode = 4;
                    end
                end
            end
            m_s2 = m_s1; m_s1 = s;
            m_p2 = m_p1; m_p1 = p;
        end
        e.st    = m_mode;
        e.act   = (r != 0 && m_mode == 1) ? 1 : 0;
        e.fr    = frog;
        e.dth   = died;
        e.lives = m_lives;
        e.level = m_level;
        e.tl    = seconds_left();
    endtask

    task automatic cyc(input int r, input int s, input int p, input int c, input int l);
        exp_t e;
        @(negedge clk);
        rst_n = r[0]; start = s[0]; pause = p[0]; coll = c[0]; lvl = l[0];
        model_step(r, s, p, c, l, e);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc_no, got, want);
        end
    endtask

    // Monitor: every edge the DUT presents a new output set to compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_no++;
            chk("state",      int'(st),    e.st);
            chk("game_active", int'(act),  e.act);
            chk("frog_reset", int'(fr),    e.fr);
            chk("death",      int'(dth),   e.dth);
            chk("lives",      int'(lives), e.lives);
            chk("level",      int'(level), e.level);
            chk("time_left",  int'(tl),    e.tl);
        end
    end

    initial begin
        int rs, rp;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; coll = 1'b0; lvl = 1'b0;
        m_mode = 0; m_lives = NB_LIVES; m_level = 0; m_played = 0; m_frozen = 0;
        m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0;

        // Reset, then a held start and an uninterrupted timeout.
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (20) cyc(1, 1, 0, 0, 0);
        repeat (40) cyc(1, 0, 0, 0, 0);
        // Second death leads to game over, then a restart.
        cyc(1, 0, 0, 1, 0);
        repeat (10) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        // Level-up pulses saturate at MAX_LEVEL.
        repeat (3) begin
            cyc(1, 0, 0, 0, 1);
            repeat (5) cyc(1, 0, 0, 0, 0);
        end
        // Pause with collision asserted, then resume.
        repeat (3) cyc(1, 0, 1, 0, 0);
        repeat (100) cyc(1, 0, 1, 1, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 1, 0, 0);
        repeat (8) cyc(1, 0, 0, 0, 0);
        // Collision together with level-up, then reset mid-freeze.
        cyc(1, 0, 0, 1, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);

        // Randomized traffic.
        rs = 0; rp = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15, 0) == 0) rs = 1 - rs;
            if ($urandom_range(11, 0) == 0) rp = 1 - rp;
            cyc(($urandom_range(399, 0) != 0) ? 1 : 0, rs, rp,
                ($urandom_range(39, 0) == 0) ? 1 : 0,
                ($urandom_range(24, 0) == 0) ? 1 : 0);
        end

        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
